button: RTL and testbench
=========================

# button

Four-input push-button conditioner for the board's north/east/south/west keys. Each raw button is synchronised to `clk`, debounced independently, and its debounced press (rising edge) produces a single-cycle pulse. The four press pulses are OR-ed onto one `btn_out` strobe that game or control logic consumes as a generic "a button was pressed" event.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 8: consecutive stable clock cycles required before a debounced level changes. Legal range 2..65535.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchroniser. Legal range 2..4.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `btn_north`  in  1  raw, asynchronous, bouncing button, active-high.
- `btn_east`  in  1  same as `btn_north`.
- `btn_south`  in  1  same as `btn_north`.
- `btn_west`  in  1  same as `btn_north`.
- `btn_out`  out  1  registered one-cycle pulse on any debounced press.

## Operation
Per-button pipeline, replicated identically for all four buttons:
- Synchroniser: `SYNC_STAGES` flip-flops in series; `s` is the last stage.
- Debouncer: holds a debounced level `d` and a counter `cnt`.
  - If `s == d`: `cnt` is cleared to 0.
  - If `s != d` and `cnt == DEBOUNCE_CYCLES-1`: `d` takes `s` and `cnt` clears.
  - Otherwise `cnt` increments.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles, high or low, is rejected.
  - Release is debounced symmetrically.
- Edge detect: `press = d & ~d_prev`, where `d_prev` is `d` delayed by one cycle.

Output:
- `btn_out` is the registered OR of the four `press` terms.
- Several buttons pressing in the same cycle give one single-cycle pulse, never a stretched one.
- A new press on one button while another is held gives a new pulse.
- A release never pulses.
- A button held indefinitely gives exactly one pulse.

Reset:
- While `rst` is high, at each clock edge all synchroniser flops, `d`, `d_prev`, `cnt` and `btn_out` clear to 0.
- A button held through reset is treated as a new press once reset is released. It pulses after the normal latency.
- Reset asserted mid-count discards the count.

## Timing
- Reset value: `btn_out` = 0. All internal state = 0.
- Latency: take edge 0 as the first rising edge that samples a stable high raw input. `btn_out` is high during the cycle after edge `SYNC_STAGES + DEBOUNCE_CYCLES + 1`, and low again after the next edge.
- Defaults: 2 + 8 + 1 = 11 edges.
- Pulse width is always exactly 1 cycle.
- A minimum low time of `DEBOUNCE_CYCLES` cycles (after sync) is required between presses for a second pulse.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit. The counter never wraps, because it clears at the terminal count.

## Structure
- Shared package `button_pkg`:
  - default `DEBOUNCE_CYCLES` and `SYNC_STAGES` constants;
  - a function computing the counter width;
  - a typedef for the 4-bit button vector, with index order north=0, east=1, south=2, west=3.
- Sub-module `button_debounce`: one button's synchroniser, debouncer and edge detector. It has ports `clk`, `rst`, `btn_in` and `press`, and takes both parameters.
- Top `button` instantiates `button_debounce` four times and registers the OR of the four `press` outputs.

## Test plan
All scenarios use the defaults and a 20 ns clock.
1. Reset and idle: hold `rst`=1 for 3 cycles, all inputs 0 → `btn_out`=0 throughout and for 20 cycles after.
2. Glitch rejection: north high 30 ns, low 20 ns, high 20 ns, low 10 ns → `btn_out` never asserts.
3. Clean press: north then held high 300 ns → exactly one 1-cycle `btn_out` pulse, 11 edges after the stable-high sample. No further pulse while held, and none on release.
4. Simultaneous press: east and west rise on the same edge and are held 20 cycles → exactly one 1-cycle pulse.
5. Staggered presses: south held; west pressed 15 cycles later and held → two separate 1-cycle pulses, 15 cycles apart.
6. Reset mid-debounce: north high, `rst` pulsed 1 cycle at cycle 5, north still held → no pulse at the original time. One pulse 11 edges after reset release; state is 0 during reset.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and types for the four-key push-button conditioner.
// Index order of the button vector: north=0, east=1, south=2, west=3.
package button_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int NUM_BUTTONS         = 4;

  localparam int BTN_NORTH = 0;
  localparam int BTN_EAST  = 1;
  localparam int BTN_SOUTH = 2;
  localparam int BTN_WEST  = 3;

  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

  // Debounce counter width: clog2 of the stable-cycle count, never below 1 bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: input synchroniser, symmetric debouncer and registered press detector.
// press is a one-cycle pulse on each debounced low-to-high transition.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   d;
  logic                   d_prev;
  logic [CW-1:0]          cnt;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // The counter only runs while s disagrees with d; agreement restarts it, so
  // any excursion shorter than DEBOUNCE_CYCLES never reaches the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      d   <= 1'b0;
      cnt <= '0;
    end else if (s == d) begin
      cnt <= '0;
    end else if (cnt == CNT_TERM) begin
      d   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev <= 1'b0;
      press  <= 1'b0;
    end else begin
      d_prev <= d;
      press  <= d & ~d_prev;
    end
  end

endmodule

// File: rtl/button.sv
// Four-key push-button conditioner: each key debounced independently, and any
// debounced press produces a single registered btn_out pulse.
module button
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_north,
  input  logic btn_east,
  input  logic btn_south,
  input  logic btn_west,
  output logic btn_out
);

  btn_vec_t btn_raw;
  btn_vec_t press;

  assign btn_raw[BTN_NORTH] = btn_north;
  assign btn_raw[BTN_EAST]  = btn_east;
  assign btn_raw[BTN_SOUTH] = btn_south;
  assign btn_raw[BTN_WEST]  = btn_west;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_raw[i]),
      .press  (press[i])
    );
  end

  // press terms are already single-cycle, so coincident presses merge into one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_out <= 1'b0;
    end else begin
      btn_out <= |press;
    end
  end

endmodule

// File: tb/tb_button.sv
// Scoreboard bench for button: a window-based reference model predicts btn_out
// every cycle, and a monitor on the falling edge compares the DUT against it.
module tb_button;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int LAT  = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_north = 1'b0;
  logic btn_east  = 1'b0;
  logic btn_south = 1'b0;
  logic btn_west  = 1'b0;
  logic btn_out;

  button #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_north (btn_north),
    .btn_east  (btn_east),
    .btn_south (btn_south),
    .btn_west  (btn_west),
    .btn_out   (btn_out)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pulse_cnt = 0;
  int pulse_at[$];
  bit expq[$];

  // Reference model: raw samples since the last reset, per button.
  bit hist[4][$];
  bit md[4];
  bit pa = 1'b0;
  bit pb = 1'b0;

  // Synchronised value seen by the debouncer at the k-th edge after reset.
  function automatic bit s_seen(int b, int k);
    int idx;
    idx = k - 1 - SYNC;
    return (idx >= 0) ? hist[b][idx] : 1'b0;
  endfunction

  // Debounced level flips when the last DEB synchronised samples all disagree with it.
  function automatic bit window_flips(int b);
    int len;
    len = hist[b].size();
    if (len < DEB) return 1'b0;
    for (int j = 0; j < DEB; j++)
      if (s_seen(b, len - j) == md[b]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit raw[4];
    bit rose;
    bit e;
    raw[0] = btn_north;
    raw[1] = btn_east;
    raw[2] = btn_south;
    raw[3] = btn_west;
    cyc++;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        hist[b].delete();
        md[b] = 1'b0;
      end
      pa = 1'b0;
      pb = 1'b0;
      e  = 1'b0;
    end else begin
      rose = 1'b0;
      for (int b = 0; b < 4; b++) begin
        hist[b].push_back(raw[b]);
        if (window_flips(b)) begin
          md[b] = ~md[b];
          if (md[b]) rose = 1'b1;
        end
      end
      e  = pb;
      pb = pa;
      pa = rose;
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin
    bit e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow cyc=%0d got=%b required=queued value", cyc, btn_out);
    end else begin
      e = expq.pop_front();
      if (btn_out !== e) begin
        errors++;
        $display("FAIL btn_out cyc=%0d got=%b required=%b", cyc, btn_out, e);
      end
    end
    if (btn_out === 1'b1) begin
      pulse_cnt++;
      pulse_at.push_back(cyc);
    end
  end

  task automatic check_eq(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_west, btn_south, btn_east, btn_north} = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pc0;
    int e0;
    int np;
    int run[4];
    logic [3:0] lvl;

    // Reset and idle
    rst = 1'b1;
    set_btns(4'b0000);
    cycles(3);
    rst = 1'b0;
    cycles(20);
    check_eq("idle_pulses", pulse_cnt, 0);

    // Sub-debounce glitches, edges kept clear of the rising clock edge
    pc0 = pulse_cnt;
    @(negedge clk);
    #5  btn_north = 1'b1;
    #30 btn_north = 1'b0;
    #20 btn_north = 1'b1;
    #20 btn_north = 1'b0;
    #10;
    cycles(20);
    check_eq("glitch_pulses", pulse_cnt - pc0, 0);

    // Clean press held 300 ns, then released
    pc0 = pulse_cnt;
    np  = pulse_at.size();
    btn_north = 1'b1;
    e0 = cyc + 1;
    cycles(15);
    btn_north = 1'b0;
    cycles(20);
    check_eq("clean_pulses", pulse_cnt - pc0, 1);
    if (pulse_at.size() > np) check_eq("clean_latency", pulse_at[np] - e0, LAT);

    // East and west together
    pc0 = pulse_cnt;
    btn_east = 1'b1;
    btn_west = 1'b1;
    cycles(20);
    set_btns(4'b0000);
    cycles(20);
    check_eq("simul_pulses", pulse_cnt - pc0, 1);

    // South held, west 15 cycles later
    pc0 = pulse_cnt;
    np  = pulse_at.size();
    btn_south = 1'b1;
    cycles(15);
    btn_west = 1'b1;
    cycles(25);
    set_btns(4'b0000);
    cycles(20);
    check_eq("stagger_pulses", pulse_cnt - pc0, 2);
    if (pulse_at.size() >= np + 2) check_eq("stagger_gap", pulse_at[np+1] - pulse_at[np], 15);

    // Reset mid-debounce with north still held
    pc0 = pulse_cnt;
    np  = pulse_at.size();
    btn_north = 1'b1;
    cycles(5);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    e0 = cyc + 1;
    cycles(20);
    btn_north = 1'b0;
    cycles(20);
    check_eq("rstmid_pulses", pulse_cnt - pc0, 1);
    if (pulse_at.size() > np) check_eq("rstmid_latency", pulse_at[np] - e0, LAT);

    // Randomised bouncing on all four keys with occasional resets
    lvl = 4'b0000;
    for (int b = 0; b < 4; b++) run[b] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (run[b] == 0) begin
          lvl[b] = ~lvl[b];
          run[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(DEB, 3 * DEB)
                                               : $urandom_range(1, DEB + 1);
        end
        run[b]--;
      end
      set_btns(lvl);
      rst = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    rst = 1'b0;
    set_btns(4'b0000);
    cycles(30);
    check_eq("final_idle_out", int'(btn_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
